tkr_cmd_serializer: RTL



---
 rtl/tkr_cmd_serializer_if.sv | 23 ++
 rtl/tkr_cmd_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tkr_cmd_serializer_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tkr_cmd_serializer_if
// Parallel command handshake into the tracker command serializer.
//   CmdValid : command presented by the event builder
//   CmdReady : serializer FIFO can accept a command
//   CmdAddr  : target board address
//   CmdCode  : command code
//   CmdData  : command payload byte
// Modports: master = command source, slave = serializer.
// -----------------------------------------------------------------------------
interface tkr_cmd_serializer_if;
  logic       CmdValid;
  logic       CmdReady;
  logic [3:0] CmdAddr;
  logic [3:0] CmdCode;
  logic [7:0] CmdData;

  modport master (output CmdValid, output CmdAddr, output CmdCode, output CmdData,
                  input  CmdReady);
  modport slave  (input  CmdValid, input  CmdAddr, input  CmdCode, input  CmdData,
                  output CmdReady);
endinterface

// File: rtl/tkr_cmd_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tkr_cmd_serializer
// Event-builder-side transmitter for the tracker board serial command line.
// Commands {addr, code, data} are queued in a small FIFO and sent MSB-first as
// a framed bit stream: start '1', addr[3:0], code[3:0], data[7:0] and, when the
// TKR_CMD_PARITY_EN macro is defined, a trailing odd-parity bit. The line idles
// low and at least GAP low cycles (plus one pop cycle) separate frames.
//
// Ports:
//   CLK       : system clock, rising edge
//   RSTn      : asynchronous active-low reset
//   cmd       : command handshake (slave modport of tkr_cmd_serializer_if)
//   ClrOvf    : clears the sticky Overflow flag (a same-cycle set wins)
//   CmdOut    : serial command line, registered
//   Busy      : FIFO non-empty or frame/gap in progress
//   TxDone    : one-cycle pulse in the first gap cycle of each frame
//   FifoCount : number of queued commands (0..2^FIFO_AW)
//   Overflow  : sticky, set when a command is offered while full
//
// Configuration macro: TKR_CMD_PARITY_EN (undefined: 17-bit frame, no parity).
// -----------------------------------------------------------------------------
module tkr_cmd_serializer #(
  parameter int FIFO_AW = 2,
  parameter int GAP     = 3
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  tkr_cmd_serializer_if.slave  cmd,
  input  logic                 ClrOvf,
  output logic                 CmdOut,
  output logic                 Busy,
  output logic                 TxDone,
  output logic [FIFO_AW:0]     FifoCount,
  output logic                 Overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
`ifdef TKR_CMD_PARITY_EN
  localparam int FRAME_LEN = 18;
`else
  localparam int FRAME_LEN = 17;
`endif
  localparam logic [FIFO_AW:0]   DEPTH_V    = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO   = (FIFO_AW+1)'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = (FIFO_AW)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO   = (FIFO_AW)'(0);
  localparam logic [4:0]         LAST_BIT_V = 5'(FRAME_LEN - 1);
  localparam logic [3:0]         GAP_LAST_V = 4'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [15:0]          mem_r [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_r;
  logic [FIFO_AW-1:0]   rd_ptr_r;
  logic [FIFO_AW:0]     count_r;
  logic [FRAME_LEN-1:0] shreg_r;
  logic [4:0]           bit_cnt_r;
  logic [3:0]           gap_cnt_r;
  logic                 cmd_out_r;
  logic                 tx_done_r;
  logic                 overflow_r;

  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 last_bit_s;
  logic                 gap_end_s;
  logic                 cmd_out_nxt_s;
  logic                 tx_done_nxt_s;
  logic [15:0]          head_s;
  logic [FRAME_LEN-1:0] frame_s;

`ifdef TKR_CMD_PARITY_EN
  // Odd parity: result makes the total number of ones (v plus parity) odd.
  function automatic logic odd_parity(input logic [15:0] v);
    return ~(^v);
  endfunction
`endif

  assign ready_s      = (count_r < DEPTH_V);
  assign cmd.CmdReady = ready_s;
  assign push_s       = cmd.CmdValid && ready_s;
  // The FSM pops only from IDLE; a push in the same cycle leaves the count unchanged.
  assign pop_s        = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
  assign last_bit_s   = (state_r == ST_SHIFT) && (bit_cnt_r == LAST_BIT_V);
  assign gap_end_s    = (gap_cnt_r == GAP_LAST_V);
  assign head_s       = mem_r[rd_ptr_r];

`ifdef TKR_CMD_PARITY_EN
  assign frame_s = {1'b1, head_s, odd_parity(head_s)};
`else
  assign frame_s = {1'b1, head_s};
`endif

  assign CmdOut    = cmd_out_r;
  assign TxDone    = tx_done_r;
  assign Overflow  = overflow_r;
  assign FifoCount = count_r;
  assign Busy      = (state_r != ST_IDLE) || (count_r != CNT_ZERO);

  // FIFO storage; entries are only read after being written, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd.CmdAddr, cmd.CmdCode, cmd.CmdData};
    end
  end

  // FIFO pointers and occupancy count; pointers wrap modulo the depth.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow in the clearing cycle keeps it set.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      overflow_r <= 1'b0;
    end else if (cmd.CmdValid && !ready_s) begin
      overflow_r <= 1'b1;
    end else if (ClrOvf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_SHIFT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit_s) state_nxt_s = ST_GAP;
        else            state_nxt_s = ST_SHIFT;
      end
      ST_GAP: begin
        if (gap_end_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next value of the line and of the done pulse.
  always_comb begin
    cmd_out_nxt_s = 1'b0;
    tx_done_nxt_s = 1'b0;
    case (state_r)
      ST_SHIFT: begin
        cmd_out_nxt_s = shreg_r[FRAME_LEN-1];
        // The edge driving the last bit also enters GAP, so the pulse lands in the first GAP cycle.
        if (last_bit_s) tx_done_nxt_s = 1'b1;
        else            tx_done_nxt_s = 1'b0;
      end
      default: begin
        cmd_out_nxt_s = 1'b0;
        tx_done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered serial line and done pulse; reset drops the line at once.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_out_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      cmd_out_r <= cmd_out_nxt_s;
      tx_done_r <= tx_done_nxt_s;
    end
  end

  // Shift register, bit counter and gap counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shreg_r   <= {FRAME_LEN{1'b0}};
      bit_cnt_r <= 5'd0;
      gap_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shreg_r   <= frame_s;
            bit_cnt_r <= 5'd0;
          end
        end
        ST_SHIFT: begin
          shreg_r   <= {shreg_r[FRAME_LEN-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 5'd1;
          if (last_bit_s) gap_cnt_r <= 4'd0;
        end
        ST_GAP: begin
          gap_cnt_r <= gap_cnt_r + 4'd1;
        end
        default: begin
          bit_cnt_r <= 5'd0;
          gap_cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule
